// File: rtl/stream_skew_ctrl.sv
// stream_skew_ctrl
// Staggered hold/reset controller for the systolic input muxes. A pass releases
// N_CH channels one after another, SKEW cycles apart, each for L beats. Passes
// are started with start/len, can loop back-to-back, and can be aborted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a pass (sampled only while idle)
//   len        beats per channel, captured with an accepted start
//   loop       sampled on the last beat: 1 = begin the next pass immediately
//   abort      synchronous return to idle, overrides start and loop
//   mux_reset  per-channel hold line, 1 = held, 0 = streaming
//   ch_valid   per-channel streaming indication (~mux_reset while busy)
//   busy       high while a pass is running
//   done       one-cycle pulse after the last beat of each pass
module stream_skew_ctrl #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SKEW  = 1,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             abort,
  output logic [N_CH-1:0]  mux_reset,
  output logic [N_CH-1:0]  ch_valid,
  output logic             busy,
  output logic             done
);

  // Counter width covers the largest last-beat index without wrapping.
  localparam int unsigned TW = LEN_W + $clog2(N_CH * SKEW) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;

  logic [TW-1:0]    t_end;
  logic [N_CH-1:0]  released;

  assign t_end = TW'((N_CH - 1) * SKEW) + TW'(len_q) - TW'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
      t_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          t_d = '0;
          if (start) begin
            if (len != '0) begin
              state_d = StRun;
              len_d   = len;
            end else begin
              // Empty pass: nothing is released, only the completion pulse.
              done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (t_q == t_end) begin
            done_d = 1'b1;
            t_d    = '0;
            if (!loop) begin
              state_d = StIdle;
            end
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      endcase
    end
  end

  // Channel i streams while i*SKEW <= t < i*SKEW + L. The unsigned difference
  // wraps to a value far above any L when t is below the window start, so one
  // compare covers both bounds.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [TW-1:0] WinLo = TW'(gi * SKEW);
    logic [TW-1:0] rel_t;
    assign rel_t         = t_q - WinLo;
    assign released[gi]  = (state_q == StRun) && (rel_t < TW'(len_q));
  end

  // Outputs, decoded from registered state only
  always_comb begin
    busy      = (state_q == StRun);
    mux_reset = ~released;
    ch_valid  = released;
    done      = done_q;
  end

endmodule

// File: tb/tb_stream_skew_ctrl.sv
// Bench for stream_skew_ctrl: two instances (4 ch / skew 1 and 3 ch / skew 2)
// share one stimulus stream and are compared every cycle against a pass-level
// reference model, plus literal pattern tables for the directed scenarios.
module tb_stream_skew_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       loop;
  logic       abort;

  logic [3:0] mux0, val0;
  logic       busy0, done0;
  logic [2:0] mux1, val1;
  logic       busy1, done1;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: pass in progress, cycles since the
  // pass began, captured length, pending completion pulse.
  int m_nch [2] = '{4, 3};
  int m_skew[2] = '{1, 2};
  bit m_busy[2];
  int m_tau [2];
  int m_len [2];
  bit m_done[2];

  always #5 clk = ~clk;

  stream_skew_ctrl #(.N_CH(4), .SKEW(1), .LEN_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len), .loop(loop), .abort(abort),
    .mux_reset(mux0), .ch_valid(val0), .busy(busy0), .done(done0)
  );

  stream_skew_ctrl #(.N_CH(3), .SKEW(2), .LEN_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .loop(loop), .abort(abort),
    .mux_reset(mux1), .ch_valid(val1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_mux(input int d);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < m_nch[d]; i++) begin
      m[i] = !(m_busy[d] && m_tau[d] >= i * m_skew[d] &&
               m_tau[d] < i * m_skew[d] + m_len[d]);
    end
    return m;
  endfunction

  function automatic logic [7:0] exp_val(input int d);
    logic [7:0] full;
    full = 8'((1 << m_nch[d]) - 1);
    return m_busy[d] ? (~exp_mux(d) & full) : 8'h00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_tau[d]  = 0;
      m_len[d]  = 0;
      m_done[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic s, input int l, input logic lp,
                            input logic ab);
    int last;
    if (ab) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
    end else if (!m_busy[d]) begin
      m_done[d] = s && (l == 0);
      if (s && l != 0) begin
        m_busy[d] = 1'b1;
        m_len[d]  = l;
        m_tau[d]  = 0;
      end
    end else begin
      last = (m_nch[d] - 1) * m_skew[d] + m_len[d] - 1;
      if (m_tau[d] == last) begin
        m_done[d] = 1'b1;
        m_tau[d]  = 0;
        if (!lp) m_busy[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        m_tau[d]++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " mux0"},  32'(mux0),  32'(exp_mux(0)));
    chk({ph, " val0"},  32'(val0),  32'(exp_val(0)));
    chk({ph, " busy0"}, 32'(busy0), 32'(m_busy[0]));
    chk({ph, " done0"}, 32'(done0), 32'(m_done[0]));
    chk({ph, " mux1"},  32'(mux1),  32'(exp_mux(1)));
    chk({ph, " val1"},  32'(val1),  32'(exp_val(1)));
    chk({ph, " busy1"}, 32'(busy1), 32'(m_busy[1]));
    chk({ph, " done1"}, 32'(done1), 32'(m_done[1]));
  endtask

  // Drive inputs, take one clock edge, advance the model, check 1 time unit later.
  task automatic cyc(input string ph, input logic s, input logic [7:0] l, input logic lp,
                     input logic ab);
    start = s;
    len   = l;
    loop  = lp;
    abort = ab;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, s, int'(l), lp, ab);
    #1;
    check_all(ph);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc("idle", 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  logic [3:0] stag_tab [7];
  logic [2:0] wide_tab [7];
  logic [3:0] loop_tab [11];
  logic [3:0] abrt_tab [5];

  initial begin
    stag_tab = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    wide_tab = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b111};
    loop_tab = '{4'b1110, 4'b1100, 4'b1001, 4'b0011, 4'b0111,
                 4'b1110, 4'b1100, 4'b1001, 4'b0011, 4'b0111, 4'b1111};
    abrt_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};

    rst   = 1'b1;
    start = 1'b0;
    len   = 8'd0;
    loop  = 1'b0;
    abort = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset hold");
    #3;
    rst = 1'b0;

    // Basic stagger, 4 channels, skew 1, len 3
    cyc("stagger", 1'b1, 8'd3, 1'b0, 1'b0);
    chk("stagger tab0", 32'(mux0), 32'(stag_tab[0]));
    for (int k = 1; k < 7; k++) begin
      cyc("stagger", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("stagger tab", 32'(mux0), 32'(stag_tab[k]));
    end
    chk("stagger done", 32'(done0), 32'd1);
    chk("stagger busy", 32'(busy0), 32'd0);
    idle_cycles(10);

    // Wide skew, 3 channels, skew 2, len 2: done in the 7th cycle
    cyc("wide", 1'b1, 8'd2, 1'b0, 1'b0);
    chk("wide tab0", 32'(mux1), 32'(wide_tab[0]));
    for (int k = 1; k < 7; k++) begin
      cyc("wide", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("wide tab", 32'(mux1), 32'(wide_tab[k]));
    end
    chk("wide done", 32'(done1), 32'd1);
    idle_cycles(10);

    // Loop once on 4-channel instance, len 2
    cyc("loop", 1'b1, 8'd2, 1'b1, 1'b0);
    chk("loop tab0", 32'(mux0), 32'(loop_tab[0]));
    for (int k = 1; k < 11; k++) begin
      cyc("loop", 1'b0, 8'd0, (k <= 5), 1'b0);
      chk("loop tab", 32'(mux0), 32'(loop_tab[k]));
      if (k == 5 || k == 10) chk("loop done", 32'(done0), 32'd1);
    end
    idle_cycles(12);

    // Zero-length start
    cyc("len0", 1'b1, 8'd0, 1'b0, 1'b0);
    chk("len0 done", 32'(done0), 32'd1);
    chk("len0 busy", 32'(busy0), 32'd0);
    chk("len0 mux", 32'(mux0), 32'hf);
    idle_cycles(2);

    // Abort at t=2, then len 1 pass
    cyc("abort", 1'b1, 8'd4, 1'b0, 1'b0);
    cyc("abort", 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("abort", 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("abort", 1'b1, 8'd0, 1'b1, 1'b1);
    chk("abort mux", 32'(mux0), 32'hf);
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort done", 32'(done0), 32'd0);
    cyc("abort", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("abort nodone", 32'(done0), 32'd0);
    cyc("abort2", 1'b1, 8'd1, 1'b0, 1'b0);
    chk("abort2 tab0", 32'(mux0), 32'(abrt_tab[0]));
    for (int k = 1; k < 5; k++) begin
      cyc("abort2", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("abort2 tab", 32'(mux0), 32'(abrt_tab[k]));
    end
    chk("abort2 done", 32'(done0), 32'd1);
    idle_cycles(6);

    // Back-to-back starts with start held high
    for (int k = 0; k < 16; k++) cyc("b2b", 1'b1, 8'd2, 1'b0, 1'b0);
    idle_cycles(10);

    // Asynchronous reset between edges at t=3
    cyc("areset", 1'b1, 8'd4, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc("areset", 1'b0, 8'd0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("areset mux", 32'(mux0), 32'hf);
    chk("areset busy", 32'(busy0), 32'd0);
    check_all("areset now");
    start = 1'b1;
    len   = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    check_all("areset start");
    #3;
    start = 1'b0;
    rst   = 1'b0;
    cyc("areset pass", 1'b1, 8'd3, 1'b0, 1'b0);
    chk("areset pass busy", 32'(busy0), 32'd1);
    idle_cycles(12);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cyc("rand", ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 6)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_skew_ctrl.md
# stream_skew_ctrl

Parametrised skew controller for the systolic matrix-multiply input muxes. It generalises the fixed 4-channel rotating reset pattern to N_CH channels, a configurable inter-channel skew and a run-time stream length. It adds a start/done handshake, abort and loop-back, so the top level can sequence repeated tile streams. It sits between the top-level sequencer and the per-row/column input muxes, driving their active-high hold/reset lines.

## Interface
- N_CH, 4: number of staggered channels (≥1).
- SKEW, 1: cycles between release of channel i and channel i+1 (≥1).
- LEN_W, 8: width of the stream-length input.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a pass; sampled only in IDLE.
- len  input  LEN_W  beats per channel; latched with start.
- loop  input  1  sampled on the last beat of a pass; 1 = start the next pass immediately.
- abort  input  1  synchronous; returns to IDLE; highest priority.
- mux_reset  output  N_CH  1 = channel mux held in reset; 0 = channel streaming.
- ch_valid  output  N_CH  equals ~mux_reset while busy, 0 otherwise.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at end of each pass.

## Operation
- States: IDLE and RUN. A cycle counter t has width LEN_W + clog2(N_CH·SKEW) + 1, sufficient for T_END without wrap.
- Latched length L = len captured on the accepted start. T_END = (N_CH−1)·SKEW + L − 1.
- IDLE:
  - mux_reset = all 1, ch_valid = 0, busy = 0, t = 0.
  - start=1 with len≠0: latch L, go to RUN with t=0.
  - start=1 with len=0: stay in IDLE and pulse done next cycle; no channel is released.
- RUN, channel window: channel i is released (mux_reset[i]=0) iff i·SKEW ≤ t ≤ i·SKEW + L − 1. Otherwise mux_reset[i]=1.
- RUN, counter: t increments by 1 each cycle.
- RUN, end of pass (t == T_END):
  - loop=0: next state IDLE and done=1 in that next cycle.
  - loop=1: t ← 0, stay in RUN, and done=1 in the next cycle, which is concurrent with beat t=0 of the new pass. L is retained; len is not resampled.
- Pass boundaries: there is no idle gap between looped passes. Channel windows of the old and new pass may not overlap because t restarts at 0.
- start while in RUN: ignored.
- len changes while in RUN: ignored.
- abort=1 in any state:
  - Next cycle: IDLE, all mux_reset=1, t=0.
  - No done pulse is generated.
  - abort overrides start and loop in the same cycle.
- All outputs are decoded from registered state (state, t, L, done register) only. There is no combinational path from any input to any output.

## Timing
- Reset (rst=1, asynchronous):
  - state=IDLE, t=0, L=0.
  - mux_reset = all 1, ch_valid = 0, busy = 0, done = 0.
  - All values are held while rst is high.
- Reset release: the first edge after rst falls may accept start.
- Start latency: start is sampled high at edge k in IDLE. From edge k: busy=1, t=0, mux_reset[0]=0.
- Channel i first release: cycle i·SKEW after entering RUN.
- Pass length: a single pass occupies T_END+1 cycles in RUN.
- done: asserted for exactly the one cycle after the last-beat cycle.
- rst mid-pass: all outputs return to reset values immediately (asynchronous), with no done pulse.
- abort mid-pass: outputs return to the IDLE values one cycle after abort is sampled.
- Back-to-back start: start held high continuously, loop=0.
  - A new pass is accepted on the edge that ends the done cycle.
  - This leaves exactly one IDLE cycle (the done cycle) between passes.

## Test plan
- Basic stagger: N_CH=4, SKEW=1, len=3, start pulse.
  - mux_reset[3:0] per RUN cycle = 1110, 1100, 1000, 0001, 0011, 0111.
  - Then 1111 with done=1 for one cycle, busy=0.
- Wide skew: N_CH=3, SKEW=2, len=2.
  - mux_reset[2:0] = 110, 110, 101, 101, 011, 011.
  - done in the 7th cycle after entering RUN.
- Loop: N_CH=4, SKEW=1, len=2, loop=1 on the first last beat, loop=0 on the second.
  - Pattern 1110, 1100, 1001, 0011, 0111 repeats twice with no gap.
  - done pulses twice, the first coincident with 1110.
- len=0 start: no channel is released, busy stays 0, done pulses once the next cycle.
- Abort at t=2 (N_CH=4, len=4):
  - Next cycle mux_reset=1111, busy=0, no done.
  - A subsequent start with len=1 yields 1110, 1101, 1011, 0111, then done.
- Async reset at t=3 applied between clock edges:
  - mux_reset=1111 and busy=0 immediately.
  - start asserted during rst is ignored.
  - After release, a normal pass runs.
